// File: rtl/vram_clear_arbiter_if.sv
// Port bundle shared by the CPU data port, the fill-engine controls and the memory side.
// The slave modport is the arbiter; the master modport is whatever surrounds it.
interface vram_clear_arbiter_if;
  logic        cpu_we;
  logic        cpu_re;
  logic [31:0] cpu_a;
  logic [31:0] cpu_wd;
  logic [31:0] cpu_rd;
  logic        cpu_stall;

  logic        clr_start;
  logic [31:0] clr_data;
  logic        clr_busy;
  logic        clr_done;

  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  cpu_we, cpu_re, cpu_a, cpu_wd, clr_start, clr_data, mem_rd,
    output cpu_rd, cpu_stall, clr_busy, clr_done, mem_we, mem_a, mem_wd
  );

  modport master (
    output cpu_we, cpu_re, cpu_a, cpu_wd, clr_start, clr_data, mem_rd,
    input  cpu_rd, cpu_stall, clr_busy, clr_done, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/vram_clear_arbiter.sv
// Shares the CPU data-memory port with a VRAM fill engine that writes a latched word
// to every VRAM location; CPU RAM traffic wins unless the engine has starved too long.
module vram_clear_arbiter #(
  parameter int unsigned VRAM_WORDS  = 700,
  parameter logic [31:0] VRAM_BASE   = 32'h0000_4000,
  parameter int unsigned ADDR_STRIDE = 4,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic               clk,
  input  logic               reset,
  vram_clear_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = (VRAM_WORDS > 1) ? $clog2(VRAM_WORDS) : 1;
  localparam int unsigned STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VRAM_WORDS - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       fill;
  logic [STV_W-1:0]  starve;

  logic              cpu_req;
  logic              cpu_vram;
  logic              cpu_own;
  logic              eng_own;
  logic              eng_last;
  logic [31:0]       eng_addr;

  // Grant decision: outside CLEAR the CPU always owns the port; inside CLEAR only
  // RAM accesses may win, and only while the starvation budget lasts.
  always_comb begin
    cpu_req  = bus.cpu_we | bus.cpu_re;
    cpu_vram = bus.cpu_a[14];
    cpu_own  = (state != CLEAR) || (cpu_req && !cpu_vram && (starve < STV_MAX));
    eng_own  = (state == CLEAR) && !cpu_own;
    eng_last = eng_own && (idx == IDX_LAST);
    eng_addr = VRAM_BASE + (32'(idx) * 32'(ADDR_STRIDE));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.clr_start) state_nxt = CLEAR;
      CLEAR:   if (eng_last)      state_nxt = DONE;
      DONE:                       state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_we    = bus.cpu_we;
    bus.mem_a     = bus.cpu_a;
    bus.mem_wd    = bus.cpu_wd;
    bus.cpu_rd    = bus.mem_rd;
    bus.cpu_stall = 1'b0;
    bus.clr_busy  = (state == CLEAR);
    bus.clr_done  = (state == DONE);
    if (eng_own) begin
      bus.mem_we    = 1'b1;
      bus.mem_a     = eng_addr;
      bus.mem_wd    = fill;
      bus.cpu_rd    = '0;
      bus.cpu_stall = cpu_req;
    end
  end

  // idx wraps to 0 on the final write so it never indexes past the last word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx    <= '0;
      fill   <= '0;
      starve <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.clr_start) begin
            fill   <= bus.clr_data;
            idx    <= '0;
            starve <= '0;
          end
        end
        CLEAR: begin
          if (eng_own) begin
            idx    <= eng_last ? '0 : idx + 1'b1;
            starve <= '0;
          end else begin
            starve <= starve + 1'b1;
          end
        end
        default: begin
          starve <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_clear_arbiter.sv
// Directed bench for vram_clear_arbiter with a word-addressed memory model behind the port.
module tb_vram_clear_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vram_clear_arbiter_if bus ();

  vram_clear_arbiter #(
    .VRAM_WORDS (700),
    .VRAM_BASE  (32'h0000_4000),
    .ADDR_STRIDE(4),
    .STARVE_MAX (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  localparam int VB = 32'h4000 >> 2;

  logic [31:0] vmem [16384];
  logic        mem_ready = 1'b0;
  int          eng_wr_cnt = 0;
  int          done_cnt = 0;

  assign bus.mem_rd = vmem[bus.mem_a[15:2]];

  // Memory model plus event counters; preloaded on the first edge with a distinct pattern.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 16384; i++) vmem[i] <= 32'h5000_0000 + 32'(i);
      vmem[8]   <= 32'h0000_1234;
      mem_ready <= 1'b1;
    end else if (bus.mem_we) begin
      vmem[bus.mem_a[15:2]] <= bus.mem_wd;
    end
    if (bus.mem_we && bus.clr_busy && bus.mem_a[14]) eng_wr_cnt <= eng_wr_cnt + 1;
    if (bus.clr_done) done_cnt <= done_cnt + 1;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int count_not(input logic [31:0] val, input int first, input int last);
    int bad = 0;
    for (int i = first; i <= last; i++) if (vmem[VB + i] !== val) bad++;
    return bad;
  endfunction

  int n;
  int stall_bad;
  int wr0;
  int dn0;

  initial begin
    reset         = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_re    = 1'b1;
    bus.cpu_a     = 32'h0000_0020;
    bus.cpu_wd    = 32'h0;
    bus.clr_start = 1'b0;
    bus.clr_data  = 32'h0;
    step;
    step;

    // Reset state
    chk("rst_busy",  32'(bus.clr_busy), 32'd0);
    chk("rst_done",  32'(bus.clr_done), 32'd0);
    chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
    chk("rst_cpu_rd", bus.cpu_rd, 32'h0000_1234);
    chk("rst_mem_a", bus.mem_a, 32'h0000_0020);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);

    // Pass-through read in IDLE
    reset = 1'b0;
    step;
    chk("pt_cpu_rd", bus.cpu_rd, 32'h0000_1234);
    chk("pt_stall",  32'(bus.cpu_stall), 32'd0);
    chk("pt_mem_we", 32'(bus.mem_we), 32'd0);
    bus.cpu_re = 1'b0;
    bus.cpu_we = 1'b1;
    bus.cpu_a  = 32'h0000_0030;
    bus.cpu_wd = 32'h0000_0077;
    #1;
    chk("pt_wr_we", 32'(bus.mem_we), 32'd1);
    chk("pt_wr_wd", bus.mem_wd, 32'h0000_0077);
    bus.cpu_we = 1'b0;

    // Reset mid-fill at idx 100
    wr0 = eng_wr_cnt; dn0 = done_cnt;
    bus.clr_start = 1'b1;
    bus.clr_data  = 32'h0000_0041;
    step;
    bus.clr_start = 1'b0;
    repeat (100) step;
    chk("rmf_addr", bus.mem_a, 32'h0000_4190);
    chk("rmf_busy", 32'(bus.clr_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("rmf_busy_off", 32'(bus.clr_busy), 32'd0);
    chk("rmf_we_follow", 32'(bus.mem_we), 32'd0);
    step;
    reset = 1'b0;
    step;
    chk("rmf_w0",   vmem[VB + 0],  32'h0000_0041);
    chk("rmf_w99",  vmem[VB + 99], 32'h0000_0041);
    chk("rmf_w100", vmem[VB + 100], 32'h5000_1064);
    chk("rmf_w699", vmem[VB + 699], 32'h5000_12BB);
    chk("rmf_writes", 32'(eng_wr_cnt - wr0), 32'd100);
    chk("rmf_no_done", 32'(done_cnt - dn0), 32'd0);

    // Idle fill
    wr0 = eng_wr_cnt; dn0 = done_cnt;
    bus.clr_start = 1'b1;
    bus.clr_data  = 32'h0000_0041;
    step;
    bus.clr_start = 1'b0;
    chk("if_first_addr", bus.mem_a, 32'h0000_4000);
    n = 0;
    while (bus.clr_busy && n < 2000) begin
      if (n == 699) chk("if_last_addr", bus.mem_a, 32'h0000_4AEC);
      n++;
      step;
    end
    chk("if_busy_cycles", 32'(n), 32'd700);
    chk("if_done_pulse", 32'(bus.clr_done), 32'd1);
    step;
    chk("if_done_low", 32'(bus.clr_done), 32'd0);
    chk("if_writes", 32'(eng_wr_cnt - wr0), 32'd700);
    chk("if_done_cnt", 32'(done_cnt - dn0), 32'd1);
    chk("if_all_41", 32'(count_not(32'h41, 0, 699)), 32'd0);
    chk("if_w700", vmem[VB + 700], 32'h5000_12BC);

    // CPU RAM priority during CLEAR
    bus.cpu_we    = 1'b1;
    bus.cpu_a     = 32'h0000_0010;
    bus.cpu_wd    = 32'hDEAD_BEEF;
    bus.clr_start = 1'b1;
    bus.clr_data  = 32'h0000_0077;
    #1;
    chk("pri_idle_a", bus.mem_a, 32'h0000_0010);
    chk("pri_idle_stall", 32'(bus.cpu_stall), 32'd0);
    step;
    bus.clr_start = 1'b0;
    n = 0;
    while (bus.clr_busy && n < 5000) begin
      if (n < 10) begin
        chk($sformatf("pri_stall_%0d", n), 32'(bus.cpu_stall), (n % 5 == 4) ? 32'd1 : 32'd0);
        chk($sformatf("pri_addr_%0d", n), bus.mem_a,
            (n % 5 == 4) ? 32'h4000 + 32'(4 * (n / 5)) : 32'h0000_0010);
      end
      n++;
      step;
    end
    chk("pri_cycles", 32'(n), 32'd3500);
    step;
    bus.cpu_we = 1'b0;
    chk("pri_ram", vmem[4], 32'hDEAD_BEEF);
    chk("pri_all_77", 32'(count_not(32'h77, 0, 699)), 32'd0);

    // CPU VRAM access stalled until DONE
    bus.clr_start = 1'b1;
    bus.clr_data  = 32'h0000_0041;
    step;
    bus.clr_start = 1'b0;
    bus.cpu_we    = 1'b1;
    bus.cpu_a     = 32'h0000_4008;
    bus.cpu_wd    = 32'h0000_005A;
    #1;
    n = 0; stall_bad = 0;
    while (bus.clr_busy && n < 2000) begin
      if (!bus.cpu_stall) stall_bad++;
      n++;
      step;
    end
    chk("vs_stalled", 32'(stall_bad), 32'd0);
    chk("vs_cycles", 32'(n), 32'd700);
    chk("vs_done", 32'(bus.clr_done), 32'd1);
    chk("vs_done_stall", 32'(bus.cpu_stall), 32'd0);
    chk("vs_done_a", bus.mem_a, 32'h0000_4008);
    step;
    bus.cpu_we = 1'b0;
    chk("vs_w2", vmem[VB + 2], 32'h0000_005A);
    chk("vs_w3", vmem[VB + 3], 32'h0000_0041);

    // Ignored restart at idx 300
    wr0 = eng_wr_cnt; dn0 = done_cnt;
    bus.clr_start = 1'b1;
    bus.clr_data  = 32'h0000_0041;
    step;
    bus.clr_start = 1'b0;
    n = 0;
    while (bus.clr_busy && n < 2000) begin
      if (n == 300) begin
        bus.clr_start = 1'b1;
        bus.clr_data  = 32'h0000_0020;
      end else begin
        bus.clr_start = 1'b0;
      end
      n++;
      step;
    end
    bus.clr_start = 1'b0;
    chk("rs_cycles", 32'(n), 32'd700);
    repeat (4) step;
    chk("rs_busy_after", 32'(bus.clr_busy), 32'd0);
    chk("rs_writes", 32'(eng_wr_cnt - wr0), 32'd700);
    chk("rs_done_cnt", 32'(done_cnt - dn0), 32'd1);
    chk("rs_all_41", 32'(count_not(32'h41, 0, 699)), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vram_clear_arbiter.md
# vram_clear_arbiter

Sits between the CPU data-memory port and the visual memory (RAM below address bit 14, VRAM at bit 14 set), sharing that single port between CPU accesses and a hardware VRAM-fill engine. On a start pulse it writes a latched fill word to every VRAM word in turn. CPU RAM traffic keeps priority, subject to an anti-starvation rule, and CPU VRAM accesses are stalled until the fill completes. It lets software clear or repaint the text screen without spending an instruction per word.

## Interface
- VRAM_WORDS, 700, number of VRAM words the engine fills.
- VRAM_BASE, 32'h0000_4000, address of VRAM word 0 (bit 14 set).
- ADDR_STRIDE, 4, address increment per VRAM word.
- STARVE_MAX, 4, consecutive engine-blocking CPU RAM grants tolerated during CLEAR before the engine is forced one cycle.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_we  in  1  CPU write strobe.
- cpu_re  in  1  CPU read request.
- cpu_a  in  32  CPU address.
- cpu_wd  in  32  CPU write data.
- cpu_rd  out  32  CPU read data.
- cpu_stall  out  1  CPU must hold its request and retry next cycle.
- clr_start  in  1  single-cycle fill start pulse.
- clr_data  in  32  fill word, sampled with clr_start.
- clr_busy  out  1  high while in CLEAR.
- clr_done  out  1  one-cycle completion pulse.
- mem_we  out  1  memory write strobe.
- mem_a  out  32  memory address.
- mem_wd  out  32  memory write data.
- mem_rd  in  32  memory read data, combinational from mem_a.

## Operation
- FSM states: IDLE, CLEAR, DONE. Registers: state, idx (clog2(VRAM_WORDS) bits), fill (32), starve (clog2(STARVE_MAX+1) bits).
- cpu_req = cpu_we | cpu_re. cpu_vram = cpu_a[14].
- IDLE:
  - CPU owns the port.
  - mem_we=cpu_we, mem_a=cpu_a, mem_wd=cpu_wd, cpu_stall=0.
  - clr_start=1: latch fill=clr_data, idx=0, starve=0, go to CLEAR.
- CLEAR, per-cycle grant:
  - CPU owns the port if cpu_req & !cpu_vram & starve<STARVE_MAX. starve increments. Engine holds idx.
  - Otherwise the engine owns the port. mem_we=1, mem_a=VRAM_BASE+idx*ADDR_STRIDE, mem_wd=fill. idx increments and starve clears. cpu_stall = cpu_req.
  - A CPU VRAM access is always stalled in CLEAR.
  - Engine write at idx=VRAM_WORDS-1: go to DONE.
- DONE:
  - Lasts 1 cycle, then returns to IDLE.
  - clr_done=1.
  - Port behaves as in IDLE. clr_start is ignored.
- clr_start in CLEAR or DONE is ignored. No queuing.
- cpu_rd = mem_rd when the CPU owns the port, else 32'h0.
- Address arithmetic is 32-bit unsigned. idx never exceeds VRAM_WORDS-1.

## Timing
- Port muxes and cpu_stall are combinational from state, starve and the CPU inputs. State updates on the rising clk edge.
- Reset:
  - state=IDLE, idx=0, fill=0, starve=0.
  - clr_busy=0, clr_done=0, cpu_stall=0, cpu_rd=mem_rd.
  - mem_we/mem_a/mem_wd follow cpu_we/cpu_a/cpu_wd.
- Reset asserted mid-CLEAR:
  - Immediate return to IDLE. No further engine writes.
  - VRAM words already written keep the fill value. No clr_done.
- Latency with no CPU traffic: clr_start sampled at edge 0; engine writes in cycles 1..VRAM_WORDS; clr_done in cycle VRAM_WORDS+1. clr_busy covers cycles 1..VRAM_WORDS.
- Each CPU RAM grant in CLEAR delays completion 1 cycle. Worst case is VRAM_WORDS*(STARVE_MAX+1) cycles.
- clr_start together with a CPU access in IDLE: the CPU access completes that cycle and CLEAR starts next cycle.
- A stalled CPU holds cpu_we/cpu_a/cpu_wd stable. The block does not capture them.

## Test plan
- Reset mid-fill: assert reset at engine idx=100 -> next cycle state=IDLE, mem_we follows cpu_we; VRAM words 0..99 = fill, word 100 onward unchanged; no clr_done.
- Idle fill: clr_start with clr_data=32'h0000_0041, no CPU traffic -> 700 writes to 32'h4000, 32'h4004 .. 32'h4AEC; clr_busy for 700 cycles; clr_done single pulse at cycle 701.
- CPU RAM priority: during CLEAR, CPU writes 32'hDEAD_BEEF to 32'h0010 continuously -> pattern of 4 CPU grants then 1 engine write with cpu_stall=1; RAM[32'h0010]=32'hDEAD_BEEF; fill completes at cycle 3500.
- CPU VRAM stall: during CLEAR, CPU writes 32'h5A to 32'h4008 -> cpu_stall=1 every cycle until DONE. The write lands in DONE and is not overwritten; final VRAM word 2 = 32'h5A.
- Ignored restart: second clr_start with clr_data=32'h20 at idx=300 -> fill stays 32'h41; exactly one clr_done; total 700 writes.
- Pass-through read: IDLE, cpu_re=1, cpu_a=32'h0020, mem_rd=32'h1234 -> cpu_rd=32'h1234, cpu_stall=0, mem_we=0.
